uart_rx_core: RTL
=================

Name: uart_rx_core

Overview:
UART receive core, the receive-side counterpart of the UART Tx path in the same UART block.
- Deserialises an oversampled RX_IN line into DATA_WD-bit words.
- Checks parity and stop bit against the same convention Tx uses: PAR_TYP=0 even, 1 odd, parity bit = XOR of data.
- Flags a valid word or an error to the downstream register-file/sync logic in the UART clock domain.

Parameters:
DATA_WD, 8, data bits per frame, LSB first
PRESCALE_WD, 6, width of Prescale input

Ports:
CLK  input  1  UART oversampling clock
RST  input  1  asynchronous active-low reset
RX_IN  input  1  serial line, idle high, already synchronised upstream
Prescale  input  PRESCALE_WD  oversampling ratio: 8, 16 or 32; any other value is treated as 8
PAR_EN  input  1  1 = frame carries a parity bit
PAR_TYP  input  1  0 = even, 1 = odd
P_DATA  output  DATA_WD  last received word
data_valid  output  1  one-cycle pulse, word good
par_err  output  1  one-cycle pulse, parity mismatch
stp_err  output  1  one-cycle pulse, stop bit sampled 0

Behaviour:
- Reset: all outputs 0. FSM in IDLE. edge_cnt, bit_cnt and shift register cleared.
- Clock and reset: one clock (CLK). Reset is asynchronous, active-low (RST). Reset mid-frame aborts the frame with no pulses.
- FSM states: IDLE, START, DATA, PARITY, STOP, DONE.
- Configuration latch: Prescale (P), PAR_EN and PAR_TYP are latched when IDLE sees RX_IN=0. Changes mid-frame are ignored.
- edge_cnt:
  - Counts 0..P-1 within each bit.
  - The IDLE cycle that sees RX_IN=0 is edge 0 of the start bit.
  - The bit ends at edge_cnt==P-1; edge_cnt then wraps to 0.
- Sampling:
  - RX_IN is sampled at edges P/2-1, P/2 and P/2+1.
  - The bit value is the 2-of-3 majority, valid from edge P/2+2.
- START:
  - If the sampled start bit is 1, it is a glitch: return to IDLE at end of bit, no pulses.
  - Otherwise go to DATA.
- DATA:
  - DATA_WD bits, shifted LSB first into the shift register; bit_cnt 0..DATA_WD-1.
  - Go to PARITY if PAR_EN=1, else STOP.
- PARITY: expected bit = ^data when PAR_TYP=0, ~^data when PAR_TYP=1. A mismatch sets an internal par_fail flag.
- STOP: a sampled 0 sets stp_fail. At end of bit go to DONE.
- DONE (one cycle):
  - P_DATA <= shift register, only if no fail flags; otherwise P_DATA holds its old value.
  - data_valid=1 iff no fails. par_err=par_fail, stp_err=stp_fail; both may pulse together.
  - Clear the flags.
  - If RX_IN=0 this cycle, treat it as edge 0 of the next start bit and go to START. Otherwise go to IDLE.
- Latency: for a frame beginning at cycle t (N = 10 + PAR_EN bits), outputs pulse at cycle t + N*P.
- Back-to-back frames are accepted with zero idle cycles.
- RX_IN=0 held permanently: each frame ends with stp_err and re-arms immediately.

Decomposition:
- Package uart_rx_pkg:
  - state_e enum
  - PRESC_8/16/32 constants
  - even/odd parity encoding, shared with Tx
- Sub-module uart_rx_sampler: edge counter, 3-point majority sampler and sample_done strobe. The FSM, shifter and checks stay in uart_rx_core.

Test Plan:
- P=8, PAR_EN=1, PAR_TYP=0, send 0xA5 with parity 0 -> at t+88: data_valid=1, P_DATA=0xA5, par_err=0, stp_err=0.
- P=16, PAR_EN=1, PAR_TYP=1, send 0x3C with parity 0 (wrong, expected 1) -> at t+176: par_err=1, data_valid=0, P_DATA unchanged.
- P=8, PAR_EN=0, send 0x81 with stop bit 0 -> at t+80: stp_err=1, data_valid=0. Then send 0x55 back-to-back -> data_valid at t+160, P_DATA=0x55.
- P=32: a 3-cycle low glitch on idle line -> FSM returns to IDLE, no pulses. One-cycle flip at edge 15 of a data bit -> majority vote recovers, word correct.
- Two frames, 0x12 then 0xEF, with zero idle gap (P=16, no parity) -> two data_valid pulses 160 cycles apart, correct words.
- RST low at DATA bit 3 of frame 0x77 -> outputs 0 immediately. Next full frame 0x77 -> data_valid with P_DATA=0x77.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared types and constants for the UART receive path.
//   state_e       receive FSM states
//   PRESC_8/16/32 supported oversampling ratios
//   PAR_EVEN/ODD  parity-type encoding, identical to the Tx path
//   par_bit()     expected parity bit for a given data XOR and parity type
package uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

  localparam int unsigned PRESC_8  = 32'd8;
  localparam int unsigned PRESC_16 = 32'd16;
  localparam int unsigned PRESC_32 = 32'd32;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Even parity: bit equals XOR of data; odd parity: its complement.
  function automatic logic par_bit(input logic data_xor, input logic par_typ);
    logic res;
    case (par_typ)
      PAR_EVEN: res = data_xor;
      PAR_ODD:  res = ~data_xor;
      default:  res = data_xor;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/uart_rx_core_if.sv
// uart_rx_core_if: received-word bus from the Rx core to the register-file/sync logic.
//   P_DATA      last good received word
//   data_valid  one-cycle pulse, word good
//   par_err     one-cycle pulse, parity mismatch
//   stp_err     one-cycle pulse, stop bit sampled 0
// Modports: master = Rx core (drives), slave = consumer.
interface uart_rx_core_if #(
  parameter int DATA_WD = 8
) ();

  logic [DATA_WD-1:0] P_DATA;
  logic               data_valid;
  logic               par_err;
  logic               stp_err;

  modport master (output P_DATA, output data_valid, output par_err, output stp_err);
  modport slave  (input  P_DATA, input  data_valid, input  par_err, input  stp_err);

endinterface

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: per-bit edge counter and 3-point majority sampler.
//   clk, rst_n   clock, asynchronous active-low reset
//   rx_in        serial line
//   presc        latched oversampling ratio (8, 16 or 32)
//   cnt_en       count this cycle (frame in progress or start edge seen)
//   sample_done  strobe on the last edge of a bit (edge presc-1)
//   bit_val      2-of-3 majority of samples at edges presc/2-1, presc/2, presc/2+1
module uart_rx_sampler #(
  parameter int PRESCALE_WD = 6
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rx_in,
  input  logic [PRESCALE_WD-1:0] presc,
  input  logic                   cnt_en,
  output logic                   sample_done,
  output logic                   bit_val
);

  localparam logic [PRESCALE_WD-1:0] ONE_C = PRESCALE_WD'(1'b1);

  logic [PRESCALE_WD-1:0] edge_cnt_r;
  logic [PRESCALE_WD-1:0] half_s;
  logic [PRESCALE_WD-1:0] smp0_s;
  logic [PRESCALE_WD-1:0] smp2_s;
  logic [PRESCALE_WD-1:0] last_s;
  logic [2:0]             smp_r;

  assign half_s = presc >> 1;
  assign smp0_s = half_s - ONE_C;
  assign smp2_s = half_s + ONE_C;
  assign last_s = presc - ONE_C;

  // Edge counter: runs 0..presc-1 while enabled, parks at 0 otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_cnt_r <= '0;
    end else if (cnt_en) begin
      if (edge_cnt_r == last_s) edge_cnt_r <= '0;
      else                      edge_cnt_r <= edge_cnt_r + ONE_C;
    end else begin
      edge_cnt_r <= '0;
    end
  end

  // Capture the three mid-bit samples; all three are rewritten every bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp_r <= 3'b000;
    end else if (cnt_en && (edge_cnt_r == smp0_s)) begin
      smp_r[0] <= rx_in;
    end else if (cnt_en && (edge_cnt_r == half_s)) begin
      smp_r[1] <= rx_in;
    end else if (cnt_en && (edge_cnt_r == smp2_s)) begin
      smp_r[2] <= rx_in;
    end else begin
      smp_r <= smp_r;
    end
  end

  assign sample_done = cnt_en && (edge_cnt_r == last_s);
  assign bit_val     = (smp_r[0] & smp_r[1]) | (smp_r[0] & smp_r[2]) | (smp_r[1] & smp_r[2]);

endmodule

// File: rtl/uart_rx_core.sv
// uart_rx_core: oversampled UART receiver (start, DATA_WD bits LSB first, optional parity, stop).
//   CLK       UART oversampling clock
//   RST       asynchronous active-low reset
//   RX_IN     serial line, idle high, already synchronised
//   Prescale  oversampling ratio 8/16/32 (others treated as 8), latched at frame start
//   PAR_EN    frame carries a parity bit (latched at frame start)
//   PAR_TYP   0 even, 1 odd (latched at frame start)
//   rx_if     P_DATA / data_valid / par_err / stp_err, all registered
module uart_rx_core
  import uart_rx_pkg::*;
#(
  parameter int DATA_WD     = 8,
  parameter int PRESCALE_WD = 6
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   RX_IN,
  input  logic [PRESCALE_WD-1:0] Prescale,
  input  logic                   PAR_EN,
  input  logic                   PAR_TYP,
  uart_rx_core_if.master         rx_if
);

  localparam int CNT_WD = $clog2(DATA_WD);
  localparam logic [CNT_WD-1:0] LAST_BIT_C = CNT_WD'(DATA_WD - 1);

  state_e                 state_r, state_nx_s;
  logic [PRESCALE_WD-1:0] presc_r, presc_dec_s;
  logic                   par_en_r, par_typ_r;
  logic [DATA_WD-1:0]     shift_r;
  logic [CNT_WD-1:0]      bit_cnt_r;
  logic                   par_fail_r;
  logic                   stp_fail_s;
  logic                   cnt_en_s, latch_s, done_go_s;
  logic                   sample_done_s, bit_val_s;
  logic [DATA_WD-1:0]     p_data_r;
  logic                   data_valid_r, par_err_r, stp_err_r;

  uart_rx_sampler #(.PRESCALE_WD(PRESCALE_WD)) u_sampler (
    .clk         (CLK),
    .rst_n       (RST),
    .rx_in       (RX_IN),
    .presc       (presc_r),
    .cnt_en      (cnt_en_s),
    .sample_done (sample_done_s),
    .bit_val     (bit_val_s)
  );

  // Map the raw Prescale input onto a supported ratio.
  always_comb begin
    presc_dec_s = PRESCALE_WD'(PRESC_8);
    if (Prescale == PRESCALE_WD'(PRESC_16))      presc_dec_s = PRESCALE_WD'(PRESC_16);
    else if (Prescale == PRESCALE_WD'(PRESC_32)) presc_dec_s = PRESCALE_WD'(PRESC_32);
    else                                         presc_dec_s = PRESCALE_WD'(PRESC_8);
  end

  // FSM state register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_r <= ST_IDLE;
    else      state_r <= state_nx_s;
  end

  // Next state plus counter enable and config latch. A low line seen in IDLE or
  // DONE is edge 0 of a start bit, so counting starts in that same cycle.
  always_comb begin
    state_nx_s = state_r;
    cnt_en_s   = 1'b0;
    latch_s    = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (!RX_IN) begin
          state_nx_s = ST_START;
          cnt_en_s   = 1'b1;
          latch_s    = 1'b1;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_START: begin
        cnt_en_s = 1'b1;
        if (sample_done_s) state_nx_s = bit_val_s ? ST_IDLE : ST_DATA;
        else               state_nx_s = ST_START;
      end
      ST_DATA: begin
        cnt_en_s = 1'b1;
        if (sample_done_s && (bit_cnt_r == LAST_BIT_C)) state_nx_s = par_en_r ? ST_PARITY : ST_STOP;
        else                                            state_nx_s = ST_DATA;
      end
      ST_PARITY: begin
        cnt_en_s = 1'b1;
        if (sample_done_s) state_nx_s = ST_STOP;
        else               state_nx_s = ST_PARITY;
      end
      ST_STOP: begin
        cnt_en_s = 1'b1;
        if (sample_done_s) state_nx_s = ST_DONE;
        else               state_nx_s = ST_STOP;
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // Outputs are registered on the STOP->DONE edge so the pulses coincide with DONE.
  assign done_go_s  = (state_r == ST_STOP) && sample_done_s;
  assign stp_fail_s = ~bit_val_s;

  // Frame configuration latch.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      presc_r   <= PRESCALE_WD'(PRESC_8);
      par_en_r  <= 1'b0;
      par_typ_r <= 1'b0;
    end else if (latch_s) begin
      presc_r   <= presc_dec_s;
      par_en_r  <= PAR_EN;
      par_typ_r <= PAR_TYP;
    end else begin
      presc_r   <= presc_r;
      par_en_r  <= par_en_r;
      par_typ_r <= par_typ_r;
    end
  end

  // Data shifter (LSB first) and data bit counter.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      shift_r   <= '0;
      bit_cnt_r <= '0;
    end else if ((state_r == ST_DATA) && sample_done_s) begin
      shift_r <= {bit_val_s, shift_r[DATA_WD-1:1]};
      if (bit_cnt_r == LAST_BIT_C) bit_cnt_r <= '0;
      else                         bit_cnt_r <= bit_cnt_r + CNT_WD'(1'b1);
    end else begin
      shift_r   <= shift_r;
      bit_cnt_r <= bit_cnt_r;
    end
  end

  // Parity-failure flag: set at the end of the parity bit, cleared per frame.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      par_fail_r <= 1'b0;
    end else if (latch_s || done_go_s) begin
      par_fail_r <= 1'b0;
    end else if ((state_r == ST_PARITY) && sample_done_s) begin
      par_fail_r <= (bit_val_s != par_bit(^shift_r, par_typ_r));
    end else begin
      par_fail_r <= par_fail_r;
    end
  end

  // Result registers: one-cycle pulses; P_DATA updates only on a clean frame.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      p_data_r     <= '0;
      data_valid_r <= 1'b0;
      par_err_r    <= 1'b0;
      stp_err_r    <= 1'b0;
    end else if (done_go_s) begin
      data_valid_r <= ~(par_fail_r | stp_fail_s);
      par_err_r    <= par_fail_r;
      stp_err_r    <= stp_fail_s;
      if (!(par_fail_r | stp_fail_s)) p_data_r <= shift_r;
      else                            p_data_r <= p_data_r;
    end else begin
      p_data_r     <= p_data_r;
      data_valid_r <= 1'b0;
      par_err_r    <= 1'b0;
      stp_err_r    <= 1'b0;
    end
  end

  assign rx_if.P_DATA     = p_data_r;
  assign rx_if.data_valid = data_valid_r;
  assign rx_if.par_err    = par_err_r;
  assign rx_if.stp_err    = stp_err_r;

endmodule
